id_ex_issue: RTL and testbench
==============================

// Module: id_ex_issue
// PURPOSE
//   Operand-issue stage and ID/EX pipeline register feeding the EX-stage logic/ALU units.
//   Resolves rs/rt operands via EX/MEM forwarding, detects load-use hazards and inserts bubbles.
//   Registers funct/logic_en/operand_1/operand_2/shamt and writeback control into EX.
//   Sits between decode/regfile read and the EX units; drives the stall back to IF/ID.
// PARAMETERS
//   DATA_W      32  operand/result width (matches `DATA_BUS)
//   FUNCT_W     6   funct field width (matches `FUNCT_BUS)
//   REG_ADDR_W  5   register address width
//   CNT_W       16  bubble performance-counter width
// PORTS
//   clk            in   1           rising-edge clock
//   rst            in   1           asynchronous, active-high reset
//   id_valid       in   1           decode holds a valid instruction
//   id_funct       in   FUNCT_W     decoded funct
//   id_logic_en    in   1           instruction targets the logic unit
//   id_rs_read     in   1           instruction reads rs
//   id_rt_read     in   1           instruction reads rt
//   id_rs_addr     in   REG_ADDR_W  rs index
//   id_rt_addr     in   REG_ADDR_W  rt index
//   id_rs_data     in   DATA_W      regfile rs value
//   id_rt_data     in   DATA_W      regfile rt value
//   id_use_imm     in   1           operand_2 comes from id_imm
//   id_imm         in   DATA_W      extended immediate
//   id_shamt       in   5           shift amount field
//   id_wr_en       in   1           writes a GPR
//   id_wr_addr     in   REG_ADDR_W  destination GPR
//   id_mem_read    in   1           instruction is a load
//   ex_fwd_wr_en   in   1           EX-stage instr writes a GPR
//   ex_fwd_addr    in   REG_ADDR_W  EX-stage destination
//   ex_fwd_data    in   DATA_W      EX-stage result
//   ex_fwd_is_load in   1           EX-stage instr is a load (data not ready)
//   mem_fwd_wr_en  in   1           MEM-stage instr writes a GPR
//   mem_fwd_addr   in   REG_ADDR_W  MEM-stage destination
//   mem_fwd_data   in   DATA_W      MEM-stage result
//   ex_stall       in   1           downstream hold (e.g. multi-cycle unit busy)
//   flush          in   1           kill the instruction in ID
//   id_stall       out  1           hold IF/ID this cycle (combinational)
//   ex_valid       out  1           EX holds a valid instruction
//   ex_funct       out  FUNCT_W     registered funct
//   ex_logic_en    out  1           registered logic enable
//   ex_operand_1   out  DATA_W      registered operand 1
//   ex_operand_2   out  DATA_W      registered operand 2
//   ex_shamt       out  5           registered shift amount
//   ex_wr_en       out  1           registered GPR write enable
//   ex_wr_addr     out  REG_ADDR_W  registered destination
//   ex_mem_read    out  1           registered load flag
//   bubble_cnt     out  CNT_W       bubbles inserted since reset, saturating
// BEHAVIOUR
//   - Reset (async, any time incl. mid-stall): all registered outputs and bubble_cnt = 0.
//   - Forwarding per source s in {rs,rt}, combinational: addr==0 -> 0;
//     else ex_fwd_wr_en & !ex_fwd_is_load & ex_fwd_addr==addr -> ex_fwd_data;
//     else mem_fwd_wr_en & mem_fwd_addr==addr -> mem_fwd_data; else regfile data. EX beats MEM.
//   - operand_1 = fwd(rs); operand_2 = id_use_imm ? id_imm : fwd(rt).
//   - load_use = id_valid & ex_fwd_wr_en & ex_fwd_is_load & ex_fwd_addr!=0 &
//     ((id_rs_read & rs==ex_fwd_addr) | (id_rt_read & !id_use_imm & rt==ex_fwd_addr)).
//   - Per-edge priority: flush > ex_stall > load_use > advance.
//     flush: register loads bubble (valid/logic_en/wr_en/mem_read=0, data fields 0).
//     ex_stall: all registered outputs hold.
//     load_use: register loads bubble; bubble_cnt += 1 (saturate at all-ones).
//     advance: register loads ID values; ex_valid=id_valid; id_valid=0 -> bubble.
//   - id_stall = !flush & (ex_stall | load_use); flush with ex_stall still loads the bubble.
//   - Latency: one cycle ID->EX; a load-use pair costs exactly one bubble.
//   - Bubble fields: wr_en=0, so no hazard/forward is ever taken from a bubble.
// TESTING
//   - Reset mid-stall: assert rst with ex_stall=1 -> all outputs 0 immediately, bubble_cnt=0.
//   - EX fwd: rs=3, ex_fwd(3,0x0000_00AA), mem_fwd(3,0x55), regfile 0x11 -> ex_operand_1=0xAA.
//   - $zero: rs=0, ex_fwd(0,0xFFFF_FFFF) -> ex_operand_1=0; id_use_imm=1, imm=0x1234 -> operand_2=0x1234.
//   - Load-use: ex_fwd_is_load, addr=5, id rt=5 -> id_stall=1, next ex_valid=0, bubble_cnt=1; then issues.
//   - ex_stall 3 cycles with new ID values -> EX outputs unchanged, id_stall=1, bubble_cnt unchanged.
//   - flush & ex_stall & load_use same cycle -> bubble loaded, id_stall=0; counter at 0xFFFF stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_issue.sv
// id_ex_issue: operand forwarding, load-use bubble insertion and ID/EX pipeline register
module id_ex_issue #(
  parameter int DATA_W     = 32,
  parameter int FUNCT_W    = 6,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [FUNCT_W-1:0]    id_funct,
  input  logic                  id_logic_en,
  input  logic                  id_rs_read,
  input  logic                  id_rt_read,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic                  id_use_imm,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [4:0]            id_shamt,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_wr_addr,
  input  logic                  id_mem_read,
  input  logic                  ex_fwd_wr_en,
  input  logic [REG_ADDR_W-1:0] ex_fwd_addr,
  input  logic [DATA_W-1:0]     ex_fwd_data,
  input  logic                  ex_fwd_is_load,
  input  logic                  mem_fwd_wr_en,
  input  logic [REG_ADDR_W-1:0] mem_fwd_addr,
  input  logic [DATA_W-1:0]     mem_fwd_data,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic [FUNCT_W-1:0]    ex_funct,
  output logic                  ex_logic_en,
  output logic [DATA_W-1:0]     ex_operand_1,
  output logic [DATA_W-1:0]     ex_operand_2,
  output logic [4:0]            ex_shamt,
  output logic                  ex_wr_en,
  output logic [REG_ADDR_W-1:0] ex_wr_addr,
  output logic                  ex_mem_read,
  output logic [CNT_W-1:0]      bubble_cnt
);
  typedef struct packed {
    logic                  valid;
    logic [FUNCT_W-1:0]    funct;
    logic                  logic_en;
    logic [DATA_W-1:0]     op1;
    logic [DATA_W-1:0]     op2;
    logic [4:0]            shamt;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic                  mem_read;
  } ex_t;
  ex_t                   r_ex, w_next;
  logic [CNT_W-1:0]      r_bubble_cnt;
  logic [DATA_W-1:0]     w_rs_fwd, w_rt_fwd;
  logic                  w_load_use;
  // a load in EX has no data yet, so only MEM or the regfile can serve that address
  always_comb begin
    w_rs_fwd = (id_rs_addr == '0) ? '0 :
               (ex_fwd_wr_en && !ex_fwd_is_load && ex_fwd_addr == id_rs_addr) ? ex_fwd_data :
               (mem_fwd_wr_en && mem_fwd_addr == id_rs_addr) ? mem_fwd_data : id_rs_data;
    w_rt_fwd = (id_rt_addr == '0) ? '0 :
               (ex_fwd_wr_en && !ex_fwd_is_load && ex_fwd_addr == id_rt_addr) ? ex_fwd_data :
               (mem_fwd_wr_en && mem_fwd_addr == id_rt_addr) ? mem_fwd_data : id_rt_data;
    w_load_use = id_valid && ex_fwd_wr_en && ex_fwd_is_load && ex_fwd_addr != '0 &&
                 ((id_rs_read && id_rs_addr == ex_fwd_addr) ||
                  (id_rt_read && !id_use_imm && id_rt_addr == ex_fwd_addr));
    w_next = '{valid: id_valid, funct: id_funct, logic_en: id_logic_en, op1: w_rs_fwd,
               op2: id_use_imm ? id_imm : w_rt_fwd, shamt: id_shamt, wr_en: id_wr_en,
               wr_addr: id_wr_addr, mem_read: id_mem_read};
  end
  assign id_stall = !flush && (ex_stall || w_load_use);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex         <= '0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      r_ex <= '0;
    end else if (!ex_stall) begin
      r_ex <= (w_load_use || !id_valid) ? ex_t'('0) : w_next;
      if (w_load_use && !(&r_bubble_cnt)) r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end
  assign ex_valid     = r_ex.valid;
  assign ex_funct     = r_ex.funct;
  assign ex_logic_en  = r_ex.logic_en;
  assign ex_operand_1 = r_ex.op1;
  assign ex_operand_2 = r_ex.op2;
  assign ex_shamt     = r_ex.shamt;
  assign ex_wr_en     = r_ex.wr_en;
  assign ex_wr_addr   = r_ex.wr_addr;
  assign ex_mem_read  = r_ex.mem_read;
  assign bubble_cnt   = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_issue.sv
// tb_id_ex_issue: directed and random checks of id_ex_issue against a behavioural model
module tb_id_ex_issue;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic        id_valid, id_logic_en, id_rs_read, id_rt_read, id_use_imm, id_wr_en, id_mem_read;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs_addr, id_rt_addr, id_shamt, id_wr_addr, ex_fwd_addr, mem_fwd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm, ex_fwd_data, mem_fwd_data;
  logic        ex_fwd_wr_en, ex_fwd_is_load, mem_fwd_wr_en, ex_stall, flush;
  logic        id_stall, ex_valid, ex_logic_en, ex_wr_en, ex_mem_read;
  logic [5:0]  ex_funct;
  logic [31:0] ex_operand_1, ex_operand_2;
  logic [4:0]  ex_shamt, ex_wr_addr;
  logic [15:0] bubble_cnt;
  int checks = 0, failures = 0;
  logic        e_valid, e_logic_en, e_wr_en, e_mem_read;
  logic [5:0]  e_funct;
  logic [31:0] e_op1, e_op2;
  logic [4:0]  e_shamt, e_wr_addr;
  logic [15:0] e_cnt;

  id_ex_issue dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_funct(id_funct), .id_logic_en(id_logic_en),
    .id_rs_read(id_rs_read), .id_rt_read(id_rt_read), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_use_imm(id_use_imm), .id_imm(id_imm), .id_shamt(id_shamt), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_mem_read(id_mem_read), .ex_fwd_wr_en(ex_fwd_wr_en),
    .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data), .ex_fwd_is_load(ex_fwd_is_load),
    .mem_fwd_wr_en(mem_fwd_wr_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_funct(ex_funct), .ex_logic_en(ex_logic_en), .ex_operand_1(ex_operand_1),
    .ex_operand_2(ex_operand_2), .ex_shamt(ex_shamt), .ex_wr_en(ex_wr_en),
    .ex_wr_addr(ex_wr_addr), .ex_mem_read(ex_mem_read), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".ex_valid"}, 64'(ex_valid), 64'(e_valid));
    chk({tag, ".ex_funct"}, 64'(ex_funct), 64'(e_funct));
    chk({tag, ".ex_logic_en"}, 64'(ex_logic_en), 64'(e_logic_en));
    chk({tag, ".ex_operand_1"}, 64'(ex_operand_1), 64'(e_op1));
    chk({tag, ".ex_operand_2"}, 64'(ex_operand_2), 64'(e_op2));
    chk({tag, ".ex_shamt"}, 64'(ex_shamt), 64'(e_shamt));
    chk({tag, ".ex_wr_en"}, 64'(ex_wr_en), 64'(e_wr_en));
    chk({tag, ".ex_wr_addr"}, 64'(ex_wr_addr), 64'(e_wr_addr));
    chk({tag, ".ex_mem_read"}, 64'(ex_mem_read), 64'(e_mem_read));
    chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(e_cnt));
  endtask

  task automatic zero_model();
    {e_valid, e_logic_en, e_wr_en, e_mem_read, e_funct, e_op1, e_op2, e_shamt, e_wr_addr} = '0;
  endtask

  // value a source register really holds at this moment in program order
  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (ex_fwd_wr_en && !ex_fwd_is_load && ex_fwd_addr == a) return ex_fwd_data;
    if (mem_fwd_wr_en && mem_fwd_addr == a) return mem_fwd_data;
    return rf;
  endfunction

  function automatic logic m_lu();
    logic hit_rs, hit_rt;
    if (!(id_valid && ex_fwd_wr_en && ex_fwd_is_load) || ex_fwd_addr == 5'd0) return 1'b0;
    hit_rs = id_rs_read && id_rs_addr == ex_fwd_addr;
    hit_rt = id_rt_read && !id_use_imm && id_rt_addr == ex_fwd_addr;
    return hit_rs || hit_rt;
  endfunction

  task automatic step(input string tag);
    logic lu;
    #2;
    lu = m_lu();
    chk({tag, ".id_stall"}, 64'(id_stall), 64'(!flush && (ex_stall || lu)));
    if (flush) zero_model();
    else if (!ex_stall) begin
      if (lu || !id_valid) begin
        zero_model();
        if (lu && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
      end else begin
        e_valid = 1'b1; e_funct = id_funct; e_logic_en = id_logic_en;
        e_op1 = m_fwd(id_rs_addr, id_rs_data);
        e_op2 = id_use_imm ? id_imm : m_fwd(id_rt_addr, id_rt_data);
        e_shamt = id_shamt; e_wr_en = id_wr_en; e_wr_addr = id_wr_addr; e_mem_read = id_mem_read;
      end
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic clear_in();
    {id_valid, id_logic_en, id_rs_read, id_rt_read, id_use_imm, id_wr_en, id_mem_read} = '0;
    {id_funct, id_rs_addr, id_rt_addr, id_shamt, id_wr_addr, ex_fwd_addr, mem_fwd_addr} = '0;
    {id_rs_data, id_rt_data, id_imm, ex_fwd_data, mem_fwd_data} = '0;
    {ex_fwd_wr_en, ex_fwd_is_load, mem_fwd_wr_en, ex_stall, flush} = '0;
  endtask

  task automatic rand_id();
    id_valid = $urandom_range(0, 3) != 0; id_funct = 6'($urandom); id_logic_en = 1'($urandom);
    id_rs_read = 1'($urandom); id_rt_read = 1'($urandom); id_use_imm = $urandom_range(0, 3) == 0;
    id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom; id_shamt = 5'($urandom);
    id_wr_en = 1'($urandom); id_wr_addr = 5'($urandom); id_mem_read = 1'($urandom);
  endtask

  task automatic rand_all();
    rand_id();
    ex_fwd_wr_en = 1'($urandom); ex_fwd_addr = 5'($urandom_range(0, 3)); ex_fwd_data = $urandom;
    ex_fwd_is_load = $urandom_range(0, 2) == 0; mem_fwd_wr_en = 1'($urandom);
    mem_fwd_addr = 5'($urandom_range(0, 3)); mem_fwd_data = $urandom;
    ex_stall = $urandom_range(0, 6) == 0; flush = $urandom_range(0, 15) == 0;
  endtask

  task automatic set_load_use();
    clear_in();
    id_valid = 1'b1; id_rt_read = 1'b1; id_rt_addr = 5'd5; id_wr_en = 1'b1; id_wr_addr = 5'd7;
    ex_fwd_wr_en = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_addr = 5'd5;
  endtask

  initial begin
    int n;
    clear_in();
    rst = 1'b1;
    zero_model(); e_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 1'b0;
    // EX result beats MEM and regfile
    id_valid = 1'b1; id_rs_read = 1'b1; id_rs_addr = 5'd3; id_rs_data = 32'h11;
    id_rt_read = 1'b1; id_rt_addr = 5'd4; id_rt_data = 32'h22; id_funct = 6'h25; id_logic_en = 1'b1;
    id_wr_en = 1'b1; id_wr_addr = 5'd9; id_shamt = 5'd3;
    ex_fwd_wr_en = 1'b1; ex_fwd_addr = 5'd3; ex_fwd_data = 32'hAA;
    mem_fwd_wr_en = 1'b1; mem_fwd_addr = 5'd3; mem_fwd_data = 32'h55;
    step("ex_fwd");
    chk("ex_fwd.op1_const", 64'(ex_operand_1), 64'h0000_00AA);
    // $zero never forwards
    id_rs_addr = 5'd0; ex_fwd_addr = 5'd0; ex_fwd_data = 32'hFFFF_FFFF; id_use_imm = 1'b1; id_imm = 32'h1234;
    step("zero");
    chk("zero.op1_const", 64'(ex_operand_1), 64'h0);
    chk("zero.op2_const", 64'(ex_operand_2), 64'h1234);
    set_load_use();
    step("load_use");
    chk("load_use.valid_const", 64'(ex_valid), 64'h0);
    chk("load_use.cnt_const", 64'(bubble_cnt), 64'h1);
    // load has moved to MEM: the dependent now issues with MEM data
    ex_fwd_wr_en = 1'b0; ex_fwd_is_load = 1'b0;
    mem_fwd_wr_en = 1'b1; mem_fwd_addr = 5'd5; mem_fwd_data = 32'hCAFE_0005;
    step("load_use_issue");
    chk("load_use_issue.op2_const", 64'(ex_operand_2), 64'hCAFE_0005);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step("ex_stall");
    end
    // async reset arrives mid-cycle while stalled
    #2;
    rst = 1'b1;
    #1;
    zero_model(); e_cnt = '0;
    chk_all("rst_mid_stall");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    ex_stall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rand_all();
      step("random");
    end
    // drive the bubble counter to saturation with back-to-back load-use cycles
    set_load_use();
    n = 32'hFFFF - int'(e_cnt);
    repeat (n) @(posedge clk);
    #1;
    zero_model(); e_cnt = 16'hFFFF;
    chk_all("saturate");
    step("saturate_hold");
    chk("saturate_hold.cnt_const", 64'(bubble_cnt), 64'hFFFF);
    mem_fwd_wr_en = 1'b1; mem_fwd_addr = 5'd5; ex_fwd_wr_en = 1'b0;
    step("refill");
    set_load_use();
    flush = 1'b1; ex_stall = 1'b1;
    step("flush_stall_lu");
    chk("flush_stall_lu.valid_const", 64'(ex_valid), 64'h0);
    chk("flush_stall_lu.cnt_const", 64'(bubble_cnt), 64'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
